// File: rtl/array_wr_ctrl_if.sv
// Write frame stream between array_state_ctrl (master) and array_wr_ctrl (slave).
// A beat transfers on any clock edge where valid && ready.
interface array_wr_ctrl_if #(
    parameter int FRAME_WIDTH = 89
) ();
    logic                   valid;
    logic [FRAME_WIDTH-1:0] data;
    logic                   ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/array_wr_ctrl.sv
// array_wr_ctrl: write-path array sequencer.
// Waits for a start pulse, takes the SOF beat of a write frame, activates the
// addressed row, issues one column write per beat with tRCD/tWR spacing,
// precharges on row change or at end of frame, and pulses array_wr_done.
// Optional: define ARRAY_WR_PARITY_EN to add array_wpar (even parity per
// data byte, registered with array_wdata).
module array_wr_ctrl #(
    parameter int ARRAY_COL_ADDR_WIDTH   = 6,
    parameter int ARRAY_ROW_ADDR_WIDTH   = 16,
    parameter int ARRAY_DATA_WIDTH       = 64,
    parameter int ARRAY_FRAME_DATA_WIDTH = 89,
    parameter int TRCD_CYC               = 4,
    parameter int TWR_CYC                = 2,
    parameter int TRP_CYC                = 3,
    parameter int TIMER_WIDTH            = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            array_wr_start,
    array_wr_ctrl_if.slave                  array_wframe,
    output logic                            array_wr_done,
    output logic                            array_row_act,
    output logic [ARRAY_ROW_ADDR_WIDTH-1:0] array_raddr,
    output logic                            array_col_wr,
    output logic [ARRAY_COL_ADDR_WIDTH-1:0] array_caddr,
    output logic [ARRAY_DATA_WIDTH-1:0]     array_wdata,
`ifdef ARRAY_WR_PARITY_EN
    output logic [ARRAY_DATA_WIDTH/8-1:0]   array_wpar,
`endif
    output logic                            array_pre,
    output logic                            array_wr_err
);

    // Frame field positions: {eof, sof, rw, data, row, col}
    localparam int ROW_LSB  = ARRAY_COL_ADDR_WIDTH;
    localparam int DATA_LSB = ROW_LSB + ARRAY_ROW_ADDR_WIDTH;
    localparam int RW_BIT   = DATA_LSB + ARRAY_DATA_WIDTH;
    localparam int SOF_BIT  = RW_BIT + 1;
    localparam int EOF_BIT  = RW_BIT + 2;

    // Timer reload values; a reload of 0 gives a zero-wait transition
    localparam logic [TIMER_WIDTH-1:0] TRCD_LOAD = TIMER_WIDTH'(TRCD_CYC - 1);
    localparam logic [TIMER_WIDTH-1:0] TWR_LOAD  = TIMER_WIDTH'(TWR_CYC - 1);
    localparam logic [TIMER_WIDTH-1:0] TRP_LOAD  = TIMER_WIDTH'(TRP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        ACT,
        WR,
        PRE,
        DONE
    } state_t;

    state_t                          state_reg;
    logic [TIMER_WIDTH-1:0]          timer_reg;
    logic                            first_pend_reg;  // SOF beat latched, write not yet issued
    logic                            eof_pend_reg;    // last beat written, precharge pending
    logic                            row_chg_reg;     // current precharge is for a row change
    logic [ARRAY_ROW_ADDR_WIDTH-1:0] next_row_reg;

    // Beat field decode
    logic [ARRAY_COL_ADDR_WIDTH-1:0] beat_col;
    logic [ARRAY_ROW_ADDR_WIDTH-1:0] beat_row;
    logic [ARRAY_DATA_WIDTH-1:0]     beat_data;
    logic                            beat_rw;
    logic                            beat_sof;
    logic                            beat_eof;

    assign beat_col  = array_wframe.data[ROW_LSB-1:0];
    assign beat_row  = array_wframe.data[DATA_LSB-1:ROW_LSB];
    assign beat_data = array_wframe.data[RW_BIT-1:DATA_LSB];
    assign beat_rw   = array_wframe.data[RW_BIT];
    assign beat_sof  = array_wframe.data[SOF_BIT];
    assign beat_eof  = array_wframe.data[EOF_BIT];

`ifdef ARRAY_WR_PARITY_EN
    logic [ARRAY_DATA_WIDTH/8-1:0] beat_par;

    generate
        for (genvar gi = 0; gi < ARRAY_DATA_WIDTH/8; gi++) begin : g_par
            assign beat_par[gi] = ^beat_data[gi*8 +: 8];
        end
    endgenerate
`endif

    logic timer_zero;
    logic beat_bad;
    logic row_match;
    logic ready_int;
    logic accept;
    logic row_change;

    assign timer_zero = (timer_reg == '0);
    // In WR a beat that is not a plain write (rw=0 or a stray SOF) is an error
    assign beat_bad   = !beat_rw || beat_sof;
    assign row_match  = (beat_row == array_raddr);
    assign accept     = array_wframe.valid && ready_int;
    // A good beat for another row, offered when a write could otherwise issue
    assign row_change = array_wframe.valid && (state_reg == WR) && timer_zero &&
                        !first_pend_reg && !eof_pend_reg && !beat_bad && !row_match;

    assign array_wframe.ready = ready_int;

    // Ready depends on state, timer and the offered beat's row, never on valid
    always_comb begin
        ready_int = 1'b0;
        case (state_reg)
            WAIT_SOF: ready_int = 1'b1;
            WR:       ready_int = timer_zero && !first_pend_reg && !eof_pend_reg &&
                                  (row_match || beat_bad);
            default:  ready_int = 1'b0;
        endcase
    end

    // Sequencer FSM with registered array outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            first_pend_reg <= 1'b0;
            eof_pend_reg   <= 1'b0;
            row_chg_reg    <= 1'b0;
            next_row_reg   <= '0;
            array_wr_done  <= 1'b0;
            array_row_act  <= 1'b0;
            array_raddr    <= '0;
            array_col_wr   <= 1'b0;
            array_caddr    <= '0;
            array_wdata    <= '0;
`ifdef ARRAY_WR_PARITY_EN
            array_wpar     <= '0;
`endif
            array_pre      <= 1'b0;
            array_wr_err   <= 1'b0;
        end else begin
            array_col_wr  <= 1'b0;
            array_wr_err  <= 1'b0;
            array_wr_done <= 1'b0;

            case (state_reg)
                IDLE: begin
                    first_pend_reg <= 1'b0;
                    eof_pend_reg   <= 1'b0;
                    row_chg_reg    <= 1'b0;
                    if (array_wr_start) begin
                        state_reg <= WAIT_SOF;
                    end
                end

                WAIT_SOF: begin
                    if (accept) begin
                        if (beat_sof && beat_rw) begin
                            // The SOF beat carries data: hold it in the output
                            // registers and strobe it once tRCD has elapsed.
                            array_raddr    <= beat_row;
                            array_row_act  <= 1'b1;
                            array_caddr    <= beat_col;
                            array_wdata    <= beat_data;
`ifdef ARRAY_WR_PARITY_EN
                            array_wpar     <= beat_par;
`endif
                            first_pend_reg <= 1'b1;
                            eof_pend_reg   <= beat_eof;
                            timer_reg      <= TRCD_LOAD;
                            state_reg      <= ACT;
                        end else begin
                            array_wr_err <= 1'b1;
                        end
                    end
                end

                ACT: begin
                    if (timer_zero) begin
                        state_reg <= WR;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                WR: begin
                    if (first_pend_reg) begin
                        if (timer_zero) begin
                            array_col_wr   <= 1'b1;
                            first_pend_reg <= 1'b0;
                            timer_reg      <= TWR_LOAD;
                        end else begin
                            timer_reg <= timer_reg - 1'b1;
                        end
                    end else if (eof_pend_reg) begin
                        // Hold the row open for tWR after the last write
                        if (timer_zero) begin
                            array_row_act <= 1'b0;
                            array_pre     <= 1'b1;
                            timer_reg     <= TRP_LOAD;
                            state_reg     <= PRE;
                        end else begin
                            timer_reg <= timer_reg - 1'b1;
                        end
                    end else if (accept) begin
                        if (beat_bad) begin
                            array_wr_err <= 1'b1;
                        end else begin
                            array_col_wr <= 1'b1;
                            array_caddr  <= beat_col;
                            array_wdata  <= beat_data;
`ifdef ARRAY_WR_PARITY_EN
                            array_wpar   <= beat_par;
`endif
                            eof_pend_reg <= beat_eof;
                            timer_reg    <= TWR_LOAD;
                        end
                    end else if (row_change) begin
                        // Beat stays on the bus and is taken after re-activation
                        next_row_reg  <= beat_row;
                        row_chg_reg   <= 1'b1;
                        array_row_act <= 1'b0;
                        array_pre     <= 1'b1;
                        timer_reg     <= TRP_LOAD;
                        state_reg     <= PRE;
                    end else if (!timer_zero) begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                PRE: begin
                    if (timer_zero) begin
                        array_pre <= 1'b0;
                        if (row_chg_reg) begin
                            row_chg_reg   <= 1'b0;
                            array_raddr   <= next_row_reg;
                            array_row_act <= 1'b1;
                            timer_reg     <= TRCD_LOAD;
                            state_reg     <= ACT;
                        end else begin
                            array_wr_done <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
